// File: rtl/sad_engine_pkg.sv
// sad_engine_pkg: shared block-size encodings, pipeline control bundle and width helpers
package sad_engine_pkg;

    typedef enum logic [1:0] {
        SZ_4   = 2'd0,
        SZ_8   = 2'd1,
        SZ_16  = 2'd2,
        SZ_16X = 2'd3
    } size_e;

    typedef struct packed {
        logic vld;
        logic first;
        logic fin;
        logic lastc;
    } ctl_t;

    function automatic int size_dim(input logic [1:0] cfg, input int cap);
        int d;
        d = (cfg == SZ_4) ? 4 : (cfg == SZ_8) ? 8 : 16;
        return (d > cap) ? cap : d;
    endfunction

    function automatic int sad_width(input int db, input int mw, input int mh);
        return db + $clog2(mw * mh);
    endfunction

endpackage

// File: rtl/sad_row_tree.sv
// sad_row_tree: masked per-lane absolute differences, then a registered row sum
module sad_row_tree #(
    parameter int DATA_BITS = 8,
    parameter int MAX_W     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [MAX_W*DATA_BITS-1:0]            cur,
    input  logic [MAX_W*DATA_BITS-1:0]            refr,
    input  logic [MAX_W-1:0]                      lane_en,
    output logic [DATA_BITS+$clog2(MAX_W)-1:0]    row_sum
);
    localparam int SUM_W = DATA_BITS + $clog2(MAX_W);

    logic [DATA_BITS-1:0] diff_q [MAX_W];
    logic [DATA_BITS-1:0] diff_d [MAX_W];
    logic [SUM_W-1:0]     sum_q, sum_d;

    function automatic logic [DATA_BITS-1:0] absdiff(input logic [DATA_BITS-1:0] a, input logic [DATA_BITS-1:0] b);
        logic signed [DATA_BITS:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[DATA_BITS] ? DATA_BITS'(-d) : d[DATA_BITS-1:0];
    endfunction

    // lanes beyond the block width are forced to zero before the first register
    always_comb begin
        for (int k = 0; k < MAX_W; k++)
            diff_d[k] = lane_en[k] ? absdiff(cur[k*DATA_BITS +: DATA_BITS], refr[k*DATA_BITS +: DATA_BITS]) : '0;
    end

    // full-width sum of the registered lane differences
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < MAX_W; k++)
            sum_d = sum_d + SUM_W'(diff_q[k]);
    end

    // stage 1 and stage 2 registers, frozen together with the rest of the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '{default: '0};
            sum_q  <= '0;
        end else if (en) begin
            diff_q <= diff_d;
            sum_q  <= sum_d;
        end
    end

    assign row_sum = sum_q;

endmodule

// File: rtl/sad_engine.sv
// sad_engine: block SAD pipeline with per-search minimum tracking
module sad_engine
    import sad_engine_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int MAX_W     = 16,
    parameter int MAX_H     = 16,
    parameter int CAND_BITS = 4,
    localparam int SAD_W    = sad_width(DATA_BITS, MAX_W, MAX_H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 cfg_size,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [MAX_W*DATA_BITS-1:0] in_cur,
    input  logic [MAX_W*DATA_BITS-1:0] in_ref,
    input  logic                       in_last,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [SAD_W-1:0]           out_sad,
    output logic                       out_best_vld,
    output logic [SAD_W-1:0]           out_best_sad,
    output logic [CAND_BITS-1:0]       out_best_idx
);
    localparam int SUM_W = DATA_BITS + $clog2(MAX_W);
    localparam int RW    = $clog2(MAX_H + 1);

    logic                 en, acc_in, row0, fin, eff_last;
    logic [1:0]           eff_size;
    int                   w, h;
    logic [MAX_W-1:0]     lane_en;
    logic [SUM_W-1:0]     row_sum;
    logic [RW-1:0]        row_q, row_d;
    logic [1:0]           size_q, size_d;
    logic                 last_q, last_d;
    ctl_t                 s1_q, s1_d, s2_q, s2_d;
    logic [SAD_W-1:0]     acc_q, acc_d, best_q, best_d, base_best;
    logic [CAND_BITS-1:0] cnt_q, cnt_d, idx_q, idx_d, base_cnt;
    logic                 has_q, has_d, base_has;
    logic                 vld_q, vld_d, bvld_q, bvld_d;
    logic                 clr, done, take;

    assign en           = !(vld_q && !out_rdy);
    assign in_rdy       = en;
    assign out_vld      = vld_q;
    assign out_sad      = acc_q;
    assign out_best_vld = bvld_q;
    assign out_best_sad = best_q;
    assign out_best_idx = idx_q;

    sad_row_tree #(.DATA_BITS(DATA_BITS), .MAX_W(MAX_W)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cur     (in_cur),
        .refr    (in_ref),
        .lane_en (lane_en),
        .row_sum (row_sum)
    );

    // row 0 takes size/last from the ports; later rows reuse the latched copies
    always_comb begin
        acc_in   = in_vld && en;
        row0     = (row_q == '0);
        eff_size = row0 ? cfg_size : size_q;
        eff_last = row0 ? in_last : last_q;
        w        = size_dim(eff_size, MAX_W);
        h        = size_dim(eff_size, MAX_H);
        fin      = (row_q == RW'(h - 1));
        for (int k = 0; k < MAX_W; k++)
            lane_en[k] = (k < w);
        size_d   = acc_in ? eff_size : size_q;
        last_d   = acc_in ? eff_last : last_q;
        row_d    = acc_in ? (fin ? '0 : row_q + 1'b1) : row_q;
        s1_d     = '{vld: acc_in, first: row0, fin: fin, lastc: eff_last};
        s2_d     = s1_q;
    end

    // accumulator, result flags and best tracker; a consumed last result restarts the search
    always_comb begin
        clr       = vld_q && bvld_q && out_rdy;
        base_cnt  = clr ? '0 : cnt_q;
        base_has  = clr ? 1'b0 : has_q;
        base_best = clr ? '0 : best_q;
        done      = s2_q.vld && s2_q.fin;
        acc_d     = s2_q.vld ? (s2_q.first ? SAD_W'(row_sum) : acc_q + SAD_W'(row_sum)) : acc_q;
        vld_d     = done;
        bvld_d    = done && s2_q.lastc;
        take      = !base_has || (acc_d < base_best);
        cnt_d     = done ? ((&base_cnt) ? base_cnt : base_cnt + 1'b1) : base_cnt;
        has_d     = done || base_has;
        best_d    = (done && take) ? acc_d : base_best;
        idx_d     = (done && take) ? base_cnt : (clr ? '0 : idx_q);
    end

    // all pipeline state advances only under the global enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            size_q <= '0;
            last_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
            acc_q  <= '0;
            vld_q  <= 1'b0;
            bvld_q <= 1'b0;
            cnt_q  <= '0;
            has_q  <= 1'b0;
            best_q <= '0;
            idx_q  <= '0;
        end else if (en) begin
            row_q  <= row_d;
            size_q <= size_d;
            last_q <= last_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            bvld_q <= bvld_d;
            cnt_q  <= cnt_d;
            has_q  <= has_d;
            best_q <= best_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: tb/tb_sad_engine.sv
// tb_sad_engine: directed block-SAD vectors with hand-computed results
module tb_sad_engine;
    localparam int DB = 8;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_size = 2'd0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [W*DB-1:0] in_cur = '0;
    logic [W*DB-1:0] in_ref = '0;
    logic          in_last = 1'b0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [15:0]   out_sad;
    logic          out_best_vld;
    logic [15:0]   out_best_sad;
    logic [3:0]    out_best_idx;

    typedef struct {
        int sad;
        int bv;
        int bs;
        int bi;
    } res_t;

    res_t q[$];
    res_t r;
    int   n_vec = 0;
    int   n_err = 0;

    sad_engine dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_size     (cfg_size),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_cur       (in_cur),
        .in_ref       (in_ref),
        .in_last      (in_last),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_sad      (out_sad),
        .out_best_vld (out_best_vld),
        .out_best_sad (out_best_sad),
        .out_best_idx (out_best_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // capture every accepted result and check the best flag stays low when idle
    always @(negedge clk) begin
        if (out_vld && out_rdy)
            q.push_back('{int'(out_sad), int'(out_best_vld), int'(out_best_sad), int'(out_best_idx)});
        if (!out_vld)
            chk("bvld_idle", int'(out_best_vld), 0);
    end

    task automatic wait_acc();
        int w = 0;
        @(negedge clk);
        while (!in_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_rdy)
            chk("in_rdy_timeout", int'(in_rdy), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [1:0] sz, input logic [1:0] sz2, input bit last,
                              input int cv, input int rv, input int c00, input int nrows);
        int d = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 8 : 16;
        int n = (nrows > 0) ? nrows : d;
        for (int rr = 0; rr < n; rr++) begin
            for (int k = 0; k < W; k++) begin
                in_cur[k*DB +: DB] = 8'((k < d) ? ((rr == 0 && k == 0) ? c00 : cv) : int'($urandom));
                in_ref[k*DB +: DB] = 8'((k < d) ? rv : int'($urandom));
            end
            cfg_size = (rr == 0) ? sz : sz2;
            in_last  = (rr == 0) ? last : !last;
            in_vld   = 1'b1;
            wait_acc();
        end
        in_vld = 1'b0;
    endtask

    task automatic get_res(output res_t o);
        int w = 0;
        while (q.size() == 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q.size() == 0) begin
            chk("res_avail", q.size(), 1);
            o = '{0, 0, 0, 0};
        end else begin
            o = q.pop_front();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_in_rdy", int'(in_rdy), 1);
        chk("rst_out_sad", int'(out_sad), 0);
        chk("rst_best_vld", int'(out_best_vld), 0);
        chk("rst_best_sad", int'(out_best_sad), 0);
        chk("rst_best_idx", int'(out_best_idx), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_block(2'd2, 2'd2, 1'b1, 255, 0, 255, 0);
        @(negedge clk);
        chk("lat16_t1", int'(out_vld), 0);
        @(negedge clk);
        chk("lat16_t2", int'(out_vld), 0);
        @(negedge clk);
        chk("lat16_t3", int'(out_vld), 1);
        chk("lat16_sad", int'(out_sad), 65280);
        get_res(r);
        chk("b16_sad", r.sad, 65280);
        chk("b16_bv", r.bv, 1);
        chk("b16_bs", r.bs, 65280);
        chk("b16_bi", r.bi, 0);

        send_block(2'd0, 2'd0, 1'b1, 10, 3, 10, 0);
        get_res(r);
        chk("b4_sad", r.sad, 112);
        chk("b4_bv", r.bv, 1);

        out_rdy = 1'b0;
        send_block(2'd1, 2'd1, 1'b0, 9, 1, 9, 0);
        fork
            send_block(2'd1, 2'd1, 1'b1, 0, 7, 0, 0);
            begin
                repeat (3) @(negedge clk);
                chk("bp_vld_rise", int'(out_vld), 1);
                chk("bp_in_rdy0", int'(in_rdy), 0);
                chk("bp_sad0", int'(out_sad), 512);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_vld_hold", int'(out_vld), 1);
                    chk("bp_in_rdy_hold", int'(in_rdy), 0);
                    chk("bp_sad_hold", int'(out_sad), 512);
                    chk("bp_bv_hold", int'(out_best_vld), 0);
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        get_res(r);
        chk("bp_res1_sad", r.sad, 512);
        chk("bp_res1_bv", r.bv, 0);
        get_res(r);
        chk("bp_res2_sad", r.sad, 448);
        chk("bp_res2_bv", r.bv, 1);
        chk("bp_res2_bs", r.bs, 448);
        chk("bp_res2_bi", r.bi, 1);

        send_block(2'd1, 2'd0, 1'b1, 5, 2, 5, 0);
        get_res(r);
        chk("tog_sad", r.sad, 192);
        chk("tog_bv", r.bv, 1);
        chk("tog_bi", r.bi, 0);

        send_block(2'd2, 2'd2, 1'b0, 200, 0, 200, 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_vld", int'(out_vld), 0);
        chk("mid_rst_sad", int'(out_sad), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_block(2'd0, 2'd0, 1'b1, 1, 0, 1, 0);
        get_res(r);
        chk("post_rst_sad", r.sad, 16);
        chk("post_rst_bs", r.bs, 16);
        chk("post_rst_bi", r.bi, 0);
        chk("post_rst_q", q.size(), 0);

        send_block(2'd0, 2'd0, 1'b0, 31, 0, 35, 0);
        send_block(2'd0, 2'd0, 1'b0, 18, 0, 30, 0);
        send_block(2'd0, 2'd0, 1'b0, 18, 0, 30, 0);
        send_block(2'd0, 2'd0, 1'b1, 43, 0, 55, 0);
        get_res(r);
        chk("srch_c0_sad", r.sad, 500);
        chk("srch_c0_bv", r.bv, 0);
        get_res(r);
        chk("srch_c1_sad", r.sad, 300);
        chk("srch_c1_bv", r.bv, 0);
        get_res(r);
        chk("srch_c2_sad", r.sad, 300);
        chk("srch_c2_bv", r.bv, 0);
        get_res(r);
        chk("srch_c3_sad", r.sad, 700);
        chk("srch_c3_bv", r.bv, 1);
        chk("srch_best_sad", r.bs, 300);
        chk("srch_best_idx", r.bi, 1);

        send_block(2'd0, 2'd0, 1'b1, 2, 0, 2, 0);
        get_res(r);
        chk("restart_sad", r.sad, 32);
        chk("restart_bs", r.bs, 32);
        chk("restart_bi", r.bi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
